flash_sequencer: RTL
====================

# flash_sequencer

Top-level controller that programs a bitstream image into SPI flash through the `spi` engine. On `start` it:
- issues one chip ERASE;
- issues one page WRITE per 256-byte page, sourcing bytes combinationally from an image memory;
- optionally read-verifies every byte with single-byte READs;
- finally issues END, which stops the flash clock.

It sits between the bootstrap top and `spi`, owning the `cmd`/`addr_in`/`data_in` side of that block.

## Interface
Parameters:
- `PAGE_BYTES`, 256, flash page size; must equal the engine's write length.
- `ADDR_W`, 24, flash/image byte address width.

Ports:
- `clk`  in  1  system clock, same clock as `spi`.
- `n_rst`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request; ignored unless idle.
- `num_pages`  in  16  pages to program; sampled on accepted `start`.
- `verify_en`  in  1  enable read-back; sampled on accepted `start`.
- `busy`  out  1  high from accepted `start` until `done`/`error`.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky verify-failure flag; cleared by next accepted `start`.
- `err_addr`  out  ADDR_W  address of the first mismatching byte.
- `pages_done`  out  16  pages written so far.
- `spi_cmd`  out  cmd_t  command to `spi`; registered.
- `spi_cmd_done`  in  1  `spi` idle indication.
- `spi_addr`  out  ADDR_W  to `spi.addr_in`.
- `spi_addr_req`  in  ADDR_W  from `spi.addr_out`; byte index within the current page.
- `spi_wdata`  out  8  to `spi.data_in`; equals `img_data`.
- `spi_rdata`  in  8  from `spi.data_out`.
- `img_addr`  out  ADDR_W  image memory read address.
- `img_data`  in  8  image memory data; combinational read, same cycle.

## Operation
- Reset values: `spi_cmd`=NONE, `busy`=0, `done`=0, `error`=0, `err_addr`=0, `pages_done`=0, all counters 0, state IDLE.
- States:
  - IDLE → ERASE on `start`. If `num_pages`==0, go directly to FINISH instead.
  - ERASE → PROG.
  - PROG → PROG while `page_idx` < `num_pages`−1, incrementing `page_idx`.
  - Last PROG → VERIFY if `verify_en`, else FINISH.
  - VERIFY → CHECK.
  - CHECK → VERIFY on match while more bytes remain; → FINISH on last match; → FAIL on mismatch.
  - FINISH issues END, then goes to DONE.
  - FAIL issues END, sets `error`, captures `err_addr`, then goes to HALT.
  - DONE pulses `done` and returns to IDLE.
  - HALT is terminal until reset, because END disables the flash clock.
- Command handshake, used by ERASE, PROG, VERIFY and END:
  - Phase ISSUE: drive `spi_cmd`; remain until `spi_cmd_done` is sampled 0.
  - Phase WAIT: keep driving the same `spi_cmd` (`spi` re-latches `cmd` every cycle during the WREN/poll loop); remain until `spi_cmd_done` is sampled 1.
  - On that same edge, register `spi_cmd`=NONE and advance.
  - END has no WAIT phase: after END is accepted, advance immediately; `spi_cmd` stays END.
- Addressing:
  - PROG: `spi_addr` = `page_idx` × PAGE_BYTES (shift by log2 PAGE_BYTES); `img_addr` = `spi_addr` + `spi_addr_req`.
  - VERIFY/CHECK: `spi_addr` = `img_addr` = `byte_idx`.
  - `byte_idx` runs 0 … `num_pages`×PAGE_BYTES−1 and is held in ADDR_W+1 bits internally, so the last-byte compare never wraps. For `num_pages`=65535 the maximum is 0xFFFEFF.
  - ERASE: `spi_addr`=0.
- CHECK compares `spi_rdata` with `img_data` at `img_addr`=`byte_idx`.
- `pages_done` increments on each PROG completion.
- A `start` received while `busy` or in HALT is ignored.
- Reset mid-operation: return to IDLE within one cycle with `spi_cmd`=NONE. Flash contents are undefined; the flash is re-erased on the next `start`.

## Timing
- All outputs change on the rising edge of `clk`. `spi` updates on the falling edge, so `spi_cmd_done` is stable at each rising edge.
- Latency from `start` to the first ERASE on `spi_cmd`: 1 cycle.
- Per command, 2 cycles of handshake overhead (ISSUE entry, NONE return) are added to the engine duration.
- CHECK: 1 cycle per byte.
- `done` asserts on the cycle after END is accepted.
- `busy` falls on the same edge that `done` rises, or on the edge that `error` is set.

## Structure
- `spi_pkg` gains the `seq_state_t` enum. `PAGE_BYTES` and its log2 live there as shared localparams, reused by `spi`.
- Sub-module `spi_handshake`: drives ISSUE/WAIT for one command and outputs `cmd_out` and a one-cycle `fin`. It is instantiated once and muxed by state.
- `spi_test` is replaced by a top that instantiates `flash_sequencer` + `spi`.

## Test plan
- `num_pages`=0, `start` → no ERASE/WRITE issued, END issued, `done` pulses, `pages_done`=0.
- `num_pages`=2, `verify_en`=0, image = address LSB, flash model → ERASE, WRITE@0x000000, WRITE@0x000100, END; model holds 0x00..0xFF twice; `done`=1, `pages_done`=2.
- Same with `verify_en`=1 → 512 READs at addresses 0..0x1FF, no `error`, `done`.
- `verify_en`=1, model corrupts byte 0x0137 → `error`=1, `err_addr`=0x000137, END issued, no `done`, later `start` ignored.
- Flash model delays the WREN bit 5 polls and write-busy 20 polls → `spi_cmd` stays WRITE through all polls, then NONE exactly one cycle after `spi_cmd_done` rises.
- `n_rst`=0 for 1 cycle during the second page → `spi_cmd`=NONE, `busy`=0 next cycle; a fresh `start` restarts with ERASE.

Source files
------------

// File: rtl/flash_sequencer_pkg.sv
// Shared types and constants for the flash programming sequencer and the SPI engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   SPI_PAGE_BYTES / SPI_PAGE_SHIFT : flash page size and its log2, shared with the engine
//   cmd_t       : command word presented to the SPI engine
//   seq_state_t : top-level sequencer states
//   hs_phase_t  : phases of a single command handshake
//   state_cmd() : which engine command a sequencer state issues
package flash_sequencer_pkg;

    localparam int SPI_PAGE_BYTES = 256;
    localparam int SPI_PAGE_SHIFT = $clog2(SPI_PAGE_BYTES);

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ERASE = 3'd1,
        CMD_WRITE = 3'd2,
        CMD_READ  = 3'd3,
        CMD_END   = 3'd4
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ERASE  = 4'd1,
        S_PROG   = 4'd2,
        S_VERIFY = 4'd3,
        S_CHECK  = 4'd4,
        S_FINISH = 4'd5,
        S_FAIL   = 4'd6,
        S_DONE   = 4'd7,
        S_HALT   = 4'd8
    } seq_state_t;

    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_ISSUE = 2'd1,
        HS_WAIT  = 2'd2
    } hs_phase_t;

    // Command owned by each sequencer state; CMD_NONE for states that
    // never talk to the engine.
    function automatic cmd_t state_cmd(input seq_state_t s);
        cmd_t c;
        case (s)
            S_ERASE:          c = CMD_ERASE;
            S_PROG:           c = CMD_WRITE;
            S_VERIFY:         c = CMD_READ;
            S_FINISH, S_FAIL: c = CMD_END;
            default:          c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/flash_sequencer_handshake.sv
// Drives one engine command through ISSUE/WAIT and reports its completion.
// Latency: cmd_out registered 1 cycle after go; fin is combinational on the completing cycle.
// Backpressure: holds the command until spi_cmd_done drops, then until it rises again.
//
// Ports:
//   clk, n_rst   : clock, synchronous active-low reset
//   go, go_cmd   : launch a command (honoured only while idle)
//   spi_cmd_done : engine idle indication, stable at each rising edge
//   cmd_out      : registered command to the engine
//   idle         : no command in flight
//   fin          : high for the single cycle on whose edge the command completes
module flash_sequencer_handshake
    import flash_sequencer_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic go,
    input  cmd_t go_cmd,
    input  logic spi_cmd_done,
    output cmd_t cmd_out,
    output logic idle,
    output logic fin
);

    hs_phase_t phase_q, phase_d;
    cmd_t      cmd_q, cmd_d;

    always_comb begin
        phase_d = phase_q;
        cmd_d   = cmd_q;
        fin     = 1'b0;
        case (phase_q)
            HS_IDLE: begin
                if (go) begin
                    phase_d = HS_ISSUE;
                    cmd_d   = go_cmd;
                end
            end
            HS_ISSUE: begin
                // The engine drops cmd_done once it has latched the command.
                if (!spi_cmd_done) begin
                    if (cmd_q == CMD_END) begin
                        // END stops the flash clock: nothing will ever come
                        // back, and the command word is left at END.
                        fin     = 1'b1;
                        phase_d = HS_IDLE;
                    end else begin
                        phase_d = HS_WAIT;
                    end
                end
            end
            HS_WAIT: begin
                // The engine re-latches cmd every cycle of its poll loop, so
                // the command stays on the bus until cmd_done returns.
                if (spi_cmd_done) begin
                    fin     = 1'b1;
                    phase_d = HS_IDLE;
                    cmd_d   = CMD_NONE;
                end
            end
            default: begin
                phase_d = HS_IDLE;
                cmd_d   = CMD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            phase_q <= HS_IDLE;
            cmd_q   <= CMD_NONE;
        end else begin
            phase_q <= phase_d;
            cmd_q   <= cmd_d;
        end
    end

    assign cmd_out = cmd_q;
    assign idle    = (phase_q == HS_IDLE);

endmodule

// File: rtl/flash_sequencer.sv
// Programs an image into SPI flash: chip erase, page writes, optional byte read-verify, END.
// Latency: ERASE on spi_cmd 1 cycle after start; 2 cycles overhead per command; 1 cycle per CHECK.
// Backpressure: each command is held until the engine's spi_cmd_done handshake completes.
//
// Ports:
//   clk, n_rst            : clock, synchronous active-low reset
//   start                 : one-cycle request, accepted only in IDLE
//   num_pages, verify_en  : job description, captured on accepted start
//   busy, done, error     : status (done is a pulse, error is sticky)
//   err_addr              : first mismatching byte address
//   pages_done            : pages written so far
//   spi_cmd, spi_cmd_done : command handshake with the SPI engine
//   spi_addr, spi_addr_req: flash address out, byte-in-page index back from the engine
//   spi_wdata, spi_rdata  : write data (image byte), read data from flash
//   img_addr, img_data    : image memory, combinational read
module flash_sequencer
    import flash_sequencer_pkg::*;
#(
    parameter int PAGE_BYTES = SPI_PAGE_BYTES,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [15:0]       num_pages,
    input  logic              verify_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       pages_done,
    output cmd_t              spi_cmd,
    input  logic              spi_cmd_done,
    output logic [ADDR_W-1:0] spi_addr,
    input  logic [ADDR_W-1:0] spi_addr_req,
    output logic [7:0]        spi_wdata,
    input  logic [7:0]        spi_rdata,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data
);

    localparam int PAGE_SHIFT = $clog2(PAGE_BYTES);

    seq_state_t        state_q, state_d;
    logic [15:0]       num_q, num_d;
    logic              ven_q, ven_d;
    logic [15:0]       page_idx_q, page_idx_d;
    // One bit wider than the address so the last-byte compare never wraps.
    logic [ADDR_W:0]   byte_idx_q, byte_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [15:0]       pages_done_q, pages_done_d;

    logic              hs_go;
    cmd_t              hs_go_cmd;
    logic              hs_idle;
    logic              hs_fin;
    cmd_t              own_cmd;

    logic [ADDR_W-1:0] page_base;
    logic [ADDR_W:0]   total_bytes;
    logic [ADDR_W:0]   byte_last;
    logic              last_page;
    logic              last_byte;
    logic              byte_match;

    // ------------------------------------------------------------------
    // Single shared handshake, launched by whichever state owns the bus.
    // ------------------------------------------------------------------
    flash_sequencer_handshake u_hs (
        .clk          (clk),
        .n_rst        (n_rst),
        .go           (hs_go),
        .go_cmd       (hs_go_cmd),
        .spi_cmd_done (spi_cmd_done),
        .cmd_out      (spi_cmd),
        .idle         (hs_idle),
        .fin          (hs_fin)
    );

    assign own_cmd = state_cmd(state_q);

    always_comb begin
        hs_go     = 1'b0;
        hs_go_cmd = CMD_NONE;
        if (state_q == S_IDLE) begin
            // Launching straight from IDLE gives the 1-cycle start-to-ERASE
            // latency; an empty job goes straight to END.
            if (start) begin
                hs_go     = 1'b1;
                hs_go_cmd = (num_pages == 16'd0) ? CMD_END : CMD_ERASE;
            end
        end else if (hs_idle && (own_cmd != CMD_NONE)) begin
            // Every later command is launched the cycle after the previous
            // one returned NONE.
            hs_go     = 1'b1;
            hs_go_cmd = own_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    assign page_base   = ADDR_W'(page_idx_q) << PAGE_SHIFT;
    assign total_bytes = (ADDR_W + 1)'(num_q) << PAGE_SHIFT;
    assign byte_last   = total_bytes - (ADDR_W + 1)'(1);
    assign last_page   = (page_idx_q == (num_q - 16'd1));
    assign last_byte   = (byte_idx_q == byte_last);
    assign byte_match  = (spi_rdata == img_data);

    always_comb begin
        spi_addr = '0;
        img_addr = '0;
        case (state_q)
            S_PROG: begin
                spi_addr = page_base;
                img_addr = page_base + spi_addr_req;
            end
            S_VERIFY, S_CHECK: begin
                spi_addr = byte_idx_q[ADDR_W-1:0];
                img_addr = byte_idx_q[ADDR_W-1:0];
            end
            default: begin
                spi_addr = '0;
                img_addr = '0;
            end
        endcase
    end

    assign spi_wdata = img_data;

    // ------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        ven_d        = ven_q;
        page_idx_d   = page_idx_q;
        byte_idx_d   = byte_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        err_addr_d   = err_addr_q;
        pages_done_d = pages_done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d        = num_pages;
                    ven_d        = verify_en;
                    page_idx_d   = '0;
                    byte_idx_d   = '0;
                    busy_d       = 1'b1;
                    error_d      = 1'b0;
                    err_addr_d   = '0;
                    pages_done_d = '0;
                    state_d      = (num_pages == 16'd0) ? S_FINISH : S_ERASE;
                end
            end
            S_ERASE: begin
                if (hs_fin) begin
                    state_d = S_PROG;
                end
            end
            S_PROG: begin
                if (hs_fin) begin
                    pages_done_d = pages_done_q + 16'd1;
                    if (last_page) begin
                        state_d = ven_q ? S_VERIFY : S_FINISH;
                    end else begin
                        page_idx_d = page_idx_q + 16'd1;
                    end
                end
            end
            S_VERIFY: begin
                if (hs_fin) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!byte_match) begin
                    // Busy drops on the same edge the error flag rises.
                    state_d    = S_FAIL;
                    error_d    = 1'b1;
                    err_addr_d = byte_idx_q[ADDR_W-1:0];
                    busy_d     = 1'b0;
                end else if (last_byte) begin
                    state_d = S_FINISH;
                end else begin
                    byte_idx_d = byte_idx_q + (ADDR_W + 1)'(1);
                    state_d    = S_VERIFY;
                end
            end
            S_FINISH: begin
                if (hs_fin) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_FAIL: begin
                if (hs_fin) begin
                    state_d = S_HALT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_HALT: begin
                // Flash clock is stopped; only a reset brings us back.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            ven_q        <= 1'b0;
            page_idx_q   <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_addr_q   <= '0;
            pages_done_q <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            ven_q        <= ven_d;
            page_idx_q   <= page_idx_d;
            byte_idx_q   <= byte_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_addr_q   <= err_addr_d;
            pages_done_q <= pages_done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_addr   = err_addr_q;
    assign pages_done = pages_done_q;

endmodule
